dm_access_unit: RTL and testbench

- Memory-stage initiator that sits between the pipeline MEM stage and the word-addressed data memory (DM).
- Accepts byte, halfword and word load/store requests with byte addresses, checks alignment and range, and drives the DM word port.
- Sub-word stores are done as a two-step read-modify-write (RMW).
- Returns sign- or zero-extended load data.
- Holds the pipeline through `busy` while a request is in flight.

---
 rtl/dm_access_unit_if.sv | 32 +++
 rtl/dm_access_unit.sv | 163 ++++++++++++++++
 tb/tb_dm_access_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_unit_if.sv
// Pipeline-side request/response and DM word-port signals of the data-memory access unit.
// The unit itself uses the slave modport; the pipeline/memory environment uses master.
interface dm_access_unit_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_sign;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       req_pc;
   logic              busy;
   logic [31:0]       rdata;
   logic              rdata_valid;
   logic              addr_err;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic              dm_write;
   logic [31:0]       dm_pc;
   logic [31:0]       dm_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc, dm_rdata,
      output busy, rdata, rdata_valid, addr_err, dm_addr, dm_wdata, dm_write, dm_pc
   );

   modport master (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc, dm_rdata,
      input  busy, rdata, rdata_valid, addr_err, dm_addr, dm_wdata, dm_write, dm_pc
   );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage initiator: validates byte/half/word requests, drives the DM word port,
// performs sub-word stores as read-modify-write and returns extended load data.
module dm_access_unit #(
   parameter int ADDR_W = 10
) (
   input logic             clk,
   input logic             reset,
   dm_access_unit_if.slave bus
);
   localparam int LA_W = ADDR_W + 2;

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [LA_W-1:0]   addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       merged_q, merged_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic              addr_err_q, addr_err_d;

   logic              hi_nz;
   logic              req_err;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [31:0]       load_ext;
   logic [31:0]       merge_val;
   logic              word_store;

   // Any byte address bit above the DM range makes the request out of range.
   generate
      if (LA_W < 32) begin : g_hi_chk
         assign hi_nz = |bus.req_addr[31:LA_W];
      end else begin : g_hi_none
         assign hi_nz = 1'b0;
      end
   endgenerate

   always_comb begin
      req_err = hi_nz;
      case (bus.req_size)
         2'd1:    if (bus.req_addr[0])            req_err = 1'b1;
         2'd2:    if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
         2'd3:    req_err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      byte_lane = 8'h00;
      for (int k = 0; k < 4; k++) begin
         if (addr_q[1:0] == k[1:0]) byte_lane = bus.dm_rdata[8*k +: 8];
      end
      half_lane = addr_q[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
      case (size_q)
         2'd0:    load_ext = {{24{sign_q & byte_lane[7]}}, byte_lane};
         2'd1:    load_ext = {{16{sign_q & half_lane[15]}}, half_lane};
         default: load_ext = bus.dm_rdata;
      endcase
   end

   // Old word with only the addressed lane replaced by the low store data.
   always_comb begin
      merge_val = bus.dm_rdata;
      if (size_q == 2'd0) begin
         for (int k = 0; k < 4; k++) begin
            if (addr_q[1:0] == k[1:0]) merge_val[8*k +: 8] = wdata_q[7:0];
         end
      end else if (addr_q[1]) begin
         merge_val[31:16] = wdata_q[15:0];
      end else begin
         merge_val[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      size_d        = size_q;
      sign_d        = sign_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      pc_d          = pc_q;
      merged_d      = merged_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      addr_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (req_err) begin
                  addr_err_d = 1'b1;
               end else begin
                  we_d    = bus.req_we;
                  size_d  = bus.req_size;
                  sign_d  = bus.req_sign;
                  addr_d  = bus.req_addr[LA_W-1:0];
                  wdata_d = bus.req_wdata;
                  pc_d    = bus.req_pc;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!we_q) begin
               rdata_d       = load_ext;
               rdata_valid_d = 1'b1;
               state_d       = IDLE;
            end else if (size_q == 2'd2) begin
               state_d = IDLE;
            end else begin
               merged_d = merge_val;
               state_d  = MERGE_WR;
            end
         end
         MERGE_WR: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         size_q        <= 2'd0;
         sign_q        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= 32'h0;
         pc_q          <= 32'h0;
         merged_q      <= 32'h0;
         rdata_q       <= 32'h0;
         rdata_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         size_q        <= size_d;
         sign_q        <= sign_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         pc_q          <= pc_d;
         merged_q      <= merged_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         addr_err_q    <= addr_err_d;
      end
   end

   // Write strobe decodes straight from state so an asynchronous reset kills it at once.
   assign word_store      = (state_q == ACCESS) && we_q && (size_q == 2'd2);
   assign bus.dm_write    = word_store || (state_q == MERGE_WR);
   assign bus.dm_wdata    = (state_q == MERGE_WR) ? merged_q : (word_store ? wdata_q : 32'h0);
   assign bus.dm_addr     = addr_q[LA_W-1:2];
   assign bus.dm_pc       = pc_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a behavioural word-addressed DM model.
module tb_dm_access_unit;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   wr_cnt = 0;
   int   rdv_cnt = 0;
   logic [31:0] mem [0:1023];

   dm_access_unit_if #(.ADDR_W(10)) bus ();
   dm_access_unit #(.ADDR_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));

   assign bus.dm_rdata = mem[bus.dm_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (bus.dm_write) begin
         mem[bus.dm_addr] <= bus.dm_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (bus.rdata_valid) rdv_cnt <= rdv_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_sign  = sign;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_pc    = pc;
      bus.req_valid = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.rdata); end
      checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b expected 0", bus.rdata_valid); end
      checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.addr_err); end
      checks++; if (bus.dm_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b expected 0", bus.dm_write); end
      checks++; if (bus.dm_addr !== 10'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.dm_addr); end
      checks++; if (bus.dm_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", bus.dm_wdata); end
      checks++; if (bus.dm_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", bus.dm_pc); end
      step();
      step();
      reset = 1'b0;
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy got %b expected 0", bus.busy); end
      $display("test_reset done");
   endtask

   task automatic test_loads();
      logic [31:0] la [6];
      logic [1:0]  sz [6];
      logic        sg [6];
      logic [31:0] ex [6];
      la = '{32'h16, 32'h16, 32'h16, 32'h14, 32'h14, 32'h15};
      sz = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
      sg = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      ex = '{32'hFFFFFF99, 32'h00000099, 32'hFFFF8899, 32'h8899AABB, 32'h0000AABB, 32'hFFFFFFAA};
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, sz[i], sg[i], la[i], 32'h0, 32'h100 + i);
         step();
         bus.req_valid = 1'b0;
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ld%0d_busy: got %b expected 1", i, bus.busy); end
         checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_rdv_early: got %b expected 0", i, bus.rdata_valid); end
         checks++; if (bus.dm_addr !== la[i][11:2]) begin errors++; $display("FAIL ld%0d_addr: got %h expected %h", i, bus.dm_addr, la[i][11:2]); end
         checks++; if (bus.dm_pc !== 32'h100 + i) begin errors++; $display("FAIL ld%0d_pc: got %h expected %h", i, bus.dm_pc, 32'h100 + i); end
         checks++; if (bus.dm_write !== 1'b0) begin errors++; $display("FAIL ld%0d_write: got %b expected 0", i, bus.dm_write); end
         step();
         checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL ld%0d_rdv: got %b expected 1", i, bus.rdata_valid); end
         checks++; if (bus.rdata !== ex[i]) begin errors++; $display("FAIL ld%0d_rdata: got %h expected %h", i, bus.rdata, ex[i]); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ld%0d_busy_end: got %b expected 0", i, bus.busy); end
         step();
         checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_rdv_pulse: got %b expected 0", i, bus.rdata_valid); end
         checks++; if (bus.rdata !== ex[i]) begin errors++; $display("FAIL ld%0d_hold: got %h expected %h", i, bus.rdata, ex[i]); end
         $display("load addr=%h size=%0d sign=%0d rdata=%h expected=%h", la[i], sz[i], sg[i], bus.rdata, ex[i]);
      end
   endtask

   task automatic test_stores();
      int wr0;
      wr0 = wr_cnt;
      drive(1'b1, 2'd0, 1'b0, 32'h15, 32'h000000CC, 32'h400);
      step();
      bus.req_valid = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sb_busy1: got %b expected 1", bus.busy); end
      checks++; if (bus.dm_write !== 1'b0) begin errors++; $display("FAIL sb_nowrite: got %b expected 0", bus.dm_write); end
      checks++; if (bus.dm_addr !== 10'd5) begin errors++; $display("FAIL sb_addr1: got %h expected 5", bus.dm_addr); end
      step();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sb_busy2: got %b expected 1", bus.busy); end
      checks++; if (bus.dm_write !== 1'b1) begin errors++; $display("FAIL sb_write: got %b expected 1", bus.dm_write); end
      checks++; if (bus.dm_wdata !== 32'h8899CCBB) begin errors++; $display("FAIL sb_wdata: got %h expected 8899ccbb", bus.dm_wdata); end
      checks++; if (bus.dm_addr !== 10'd5) begin errors++; $display("FAIL sb_addr2: got %h expected 5", bus.dm_addr); end
      checks++; if (bus.dm_pc !== 32'h400) begin errors++; $display("FAIL sb_pc: got %h expected 400", bus.dm_pc); end
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sb_busy3: got %b expected 0", bus.busy); end
      checks++; if (mem[5] !== 32'h8899CCBB) begin errors++; $display("FAIL sb_mem: got %h expected 8899ccbb", mem[5]); end
      checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL sb_pulses: got %0d expected 1", wr_cnt - wr0); end
      $display("store byte addr=15 mem[5]=%h", mem[5]);

      drive(1'b1, 2'd1, 1'b0, 32'h16, 32'h1234BEEF, 32'h404);
      step();
      bus.req_valid = 1'b0;
      step();
      checks++; if (bus.dm_wdata !== 32'hBEEFCCBB) begin errors++; $display("FAIL sh_wdata: got %h expected beefccbb", bus.dm_wdata); end
      step();
      checks++; if (mem[5] !== 32'hBEEFCCBB) begin errors++; $display("FAIL sh_mem: got %h expected beefccbb", mem[5]); end
      $display("store half addr=16 mem[5]=%h", mem[5]);

      drive(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h408);
      step();
      bus.req_valid = 1'b0;
      checks++; if (bus.dm_write !== 1'b1) begin errors++; $display("FAIL sw_write: got %b expected 1", bus.dm_write); end
      checks++; if (bus.dm_wdata !== 32'h11223344) begin errors++; $display("FAIL sw_wdata: got %h expected 11223344", bus.dm_wdata); end
      checks++; if (bus.dm_addr !== 10'd8) begin errors++; $display("FAIL sw_addr: got %h expected 8", bus.dm_addr); end
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sw_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.dm_write !== 1'b0) begin errors++; $display("FAIL sw_write_end: got %b expected 0", bus.dm_write); end
      checks++; if (mem[8] !== 32'h11223344) begin errors++; $display("FAIL sw_mem: got %h expected 11223344", mem[8]); end
      $display("store word addr=20 mem[8]=%h", mem[8]);
   endtask

   task automatic test_errors();
      logic [1:0]  sz [4];
      logic [31:0] ad [4];
      int wr0;
      int rdv0;
      sz = '{2'd2, 2'd1, 2'd3, 2'd2};
      ad = '{32'h6, 32'h3, 32'h10, 32'h1000};
      wr0  = wr_cnt;
      rdv0 = rdv_cnt;
      for (int i = 0; i < 4; i++) begin
         drive(i[0], sz[i], 1'b0, ad[i], 32'hDEADBEEF, 32'h200 + i);
         step();
         bus.req_valid = 1'b0;
         checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL err%0d_pulse: got %b expected 1", i, bus.addr_err); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL err%0d_busy: got %b expected 0", i, bus.busy); end
         checks++; if (bus.dm_write !== 1'b0) begin errors++; $display("FAIL err%0d_write: got %b expected 0", i, bus.dm_write); end
         checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL err%0d_rdv: got %b expected 0", i, bus.rdata_valid); end
         step();
         checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL err%0d_clear: got %b expected 0", i, bus.addr_err); end
         $display("reject size=%0d addr=%h addr_err pulsed", sz[i], ad[i]);
      end
      checks++; if (wr_cnt !== wr0) begin errors++; $display("FAIL err_writes: got %0d expected %0d", wr_cnt, wr0); end
      checks++; if (rdv_cnt !== rdv0) begin errors++; $display("FAIL err_rdv: got %0d expected %0d", rdv_cnt, rdv0); end
   endtask

   task automatic test_reset_mid_rmw();
      int wr0;
      mem[7] = 32'h01020304;
      wr0 = wr_cnt;
      drive(1'b1, 2'd1, 1'b0, 32'h1E, 32'h0000BEEF, 32'h500);
      step();
      bus.req_valid = 1'b0;
      step();
      checks++; if (bus.dm_write !== 1'b1) begin errors++; $display("FAIL rmw_write: got %b expected 1", bus.dm_write); end
      checks++; if (bus.dm_wdata !== 32'hBEEF0304) begin errors++; $display("FAIL rmw_wdata: got %h expected beef0304", bus.dm_wdata); end
      reset = 1'b1;
      #1;
      checks++; if (bus.dm_write !== 1'b0) begin errors++; $display("FAIL rmw_rst_write: got %b expected 0", bus.dm_write); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmw_rst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rmw_rst_rdata: got %h expected 0", bus.rdata); end
      checks++; if (bus.dm_addr !== 10'h0) begin errors++; $display("FAIL rmw_rst_addr: got %h expected 0", bus.dm_addr); end
      checks++; if (bus.dm_wdata !== 32'h0) begin errors++; $display("FAIL rmw_rst_wdata: got %h expected 0", bus.dm_wdata); end
      checks++; if (bus.dm_pc !== 32'h0) begin errors++; $display("FAIL rmw_rst_pc: got %h expected 0", bus.dm_pc); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (mem[7] !== 32'h01020304) begin errors++; $display("FAIL rmw_mem: got %h expected 01020304", mem[7]); end
      checks++; if (wr_cnt !== wr0) begin errors++; $display("FAIL rmw_writes: got %0d expected %0d", wr_cnt, wr0); end
      $display("reset during merge: mem[7]=%h", mem[7]);
   endtask

   task automatic test_back_to_back();
      int wr0;
      int rdv0;
      drive(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h5FC);
      step();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
      drive(1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFEF00D, 32'h600);
      step();
      checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL b2b_rdv: got %b expected 1", bus.rdata_valid); end
      checks++; if (bus.rdata !== 32'hBEEFCCBB) begin errors++; $display("FAIL b2b_rdata: got %h expected beefccbb", bus.rdata); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", bus.busy); end
      step();
      bus.req_valid = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", bus.busy); end
      checks++; if (bus.dm_write !== 1'b1) begin errors++; $display("FAIL b2b_write: got %b expected 1", bus.dm_write); end
      checks++; if (bus.dm_addr !== 10'd9) begin errors++; $display("FAIL b2b_addr: got %h expected 9", bus.dm_addr); end
      checks++; if (bus.dm_pc !== 32'h600) begin errors++; $display("FAIL b2b_pc: got %h expected 600", bus.dm_pc); end
      checks++; if (bus.rdata !== 32'hBEEFCCBB) begin errors++; $display("FAIL b2b_hold: got %h expected beefccbb", bus.rdata); end
      step();
      checks++; if (mem[9] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_mem: got %h expected cafef00d", mem[9]); end
      $display("back-to-back load=%h then store mem[9]=%h", bus.rdata, mem[9]);

      mem[10] = 32'h0;
      wr0  = wr_cnt;
      rdv0 = rdv_cnt;
      drive(1'b1, 2'd0, 1'b0, 32'h28, 32'h0000005A, 32'h700);
      step();
      bus.req_we   = 1'b0;
      bus.req_addr = 32'h2C;
      bus.req_valid = 1'b0; #2; bus.req_valid = 1'b1; #2; bus.req_valid = 1'b0; #2; bus.req_valid = 1'b1;
      step();
      checks++; if (bus.dm_write !== 1'b1) begin errors++; $display("FAIL tog_write: got %b expected 1", bus.dm_write); end
      checks++; if (bus.dm_addr !== 10'd10) begin errors++; $display("FAIL tog_addr: got %h expected a", bus.dm_addr); end
      bus.req_valid = 1'b0; #2; bus.req_valid = 1'b1; #2; bus.req_valid = 1'b0;
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tog_busy: got %b expected 0", bus.busy); end
      checks++; if (mem[10] !== 32'h0000005A) begin errors++; $display("FAIL tog_mem: got %h expected 0000005a", mem[10]); end
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tog_idle: got %b expected 0", bus.busy); end
      checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL tog_writes: got %0d expected 1", wr_cnt - wr0); end
      checks++; if (rdv_cnt !== rdv0) begin errors++; $display("FAIL tog_rdv: got %0d expected %0d", rdv_cnt, rdv0); end
      $display("toggle while busy: writes=%0d mem[10]=%h", wr_cnt - wr0, mem[10]);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[5]        = 32'h8899AABB;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'd0;
      bus.req_sign  = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.req_pc    = 32'h0;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_reset_mid_rmw();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
